// File: rtl/opc5ls_uart_if.sv
// OPC5LS CPU bus as seen by a memory-mapped peripheral.
// The CPU drives address/data/direction; the peripheral returns read data and its select.
interface opc5ls_uart_if;
   logic [15:0] address;
   logic [15:0] wdata;
   logic        rnw;
   logic [15:0] rdata;
   logic        sel;

   modport master (output address, output wdata, output rnw, input rdata, input sel);
   modport slave  (input address, input wdata, input rnw, output rdata, output sel);
endinterface

// File: rtl/opc5ls_uart.sv
// Memory-mapped 8N1 UART for the OPC5LS bus: DATA/STATUS registers, TX shifter,
// RX sampler on a synchronised rxd, and a small RX FIFO. Reads are combinational.
module opc5ls_uart #(
   parameter logic [15:0] BASE_ADDR     = 16'hFE00,
   parameter int unsigned CLKS_PER_BIT  = 217,
   parameter int unsigned RX_FIFO_DEPTH = 4
) (
   input  logic           clk,
   input  logic           reset_b,
   opc5ls_uart_if.slave   bus,
   output logic           txd,
   input  logic           rxd
);
   localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
   localparam int unsigned AW   = $clog2(RX_FIFO_DEPTH);
   localparam int unsigned CNTW = AW + 1;
   localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(RX_FIFO_DEPTH);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   tx_state_t       tx_state;
   logic [CW-1:0]   tx_cnt;
   logic [2:0]      tx_bit;
   logic [7:0]      tx_shift;

   rx_state_t       rx_state;
   logic [CW-1:0]   rx_cnt;
   logic [2:0]      rx_bit;
   logic [7:0]      rx_shift;
   logic [7:0]      rx_byte;
   logic            rx_push;
   logic            ferr_set;
   logic            rx_s1, rx_s2, rx_s3;

   logic [7:0]      mem [RX_FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CNTW-1:0] count;
   logic            full, empty, push, pop, ovr_set;
   logic            ovr, ferr;

   logic            hit, data_rd, stat_rd, data_wr;
   logic            data_rd_q, stat_rd_q;
   logic            pop_req, clr_flags;
   logic [15:0]     rdata_c;

   assign hit     = (bus.address[15:1] == BASE_ADDR[15:1]);
   assign data_rd = hit & bus.rnw & ~bus.address[0];
   assign stat_rd = hit & bus.rnw & bus.address[0];
   assign data_wr = hit & ~bus.rnw & ~bus.address[0];
   assign bus.sel = hit;

   // Read side effects fire only on the first cycle of a held access.
   assign pop_req   = data_rd & ~data_rd_q;
   assign clr_flags = stat_rd & ~stat_rd_q;

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         data_rd_q <= 1'b0;
         stat_rd_q <= 1'b0;
      end else begin
         data_rd_q <= data_rd;
         stat_rd_q <= stat_rd;
      end
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         tx_state <= TX_IDLE;
         txd      <= 1'b1;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
      end else begin
         case (tx_state)
            TX_IDLE: begin
               if (data_wr) begin
                  tx_shift <= bus.wdata[7:0];
                  tx_state <= TX_START;
                  txd      <= 1'b0;
                  tx_cnt   <= '0;
               end
            end
            TX_START: begin
               if (tx_cnt == BIT_LAST) begin
                  tx_cnt   <= '0;
                  tx_bit   <= '0;
                  txd      <= tx_shift[0];
                  tx_state <= TX_DATA;
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            TX_DATA: begin
               if (tx_cnt == BIT_LAST) begin
                  tx_cnt <= '0;
                  if (tx_bit == 3'd7) begin
                     txd      <= 1'b1;
                     tx_state <= TX_STOP;
                  end else begin
                     tx_bit   <= tx_bit + 1'b1;
                     tx_shift <= {1'b0, tx_shift[7:1]};
                     txd      <= tx_shift[1];
                  end
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            TX_STOP: begin
               if (tx_cnt == BIT_LAST) begin
                  tx_cnt   <= '0;
                  tx_state <= TX_IDLE;
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_s3    <= 1'b1;
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
         rx_byte  <= '0;
         rx_push  <= 1'b0;
         ferr_set <= 1'b0;
      end else begin
         rx_s1    <= rxd;
         rx_s2    <= rx_s1;
         rx_s3    <= rx_s2;
         rx_push  <= 1'b0;
         ferr_set <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               if (rx_s3 & ~rx_s2) begin
                  rx_state <= RX_START;
                  rx_cnt   <= '0;
               end
            end
            RX_START: begin
               if (rx_cnt == HALF_LAST) begin
                  rx_cnt   <= '0;
                  rx_bit   <= '0;
                  rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (rx_cnt == BIT_LAST) begin
                  rx_cnt   <= '0;
                  rx_shift <= {rx_s2, rx_shift[7:1]};
                  rx_bit   <= rx_bit + 1'b1;
                  if (rx_bit == 3'd7) rx_state <= RX_STOP;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (rx_cnt == BIT_LAST) begin
                  rx_cnt   <= '0;
                  rx_state <= RX_IDLE;
                  if (rx_s2) begin
                     rx_byte <= rx_shift;
                     rx_push <= 1'b1;
                  end else begin
                     ferr_set <= 1'b1;
                  end
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
         endcase
      end
   end

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   assign pop   = pop_req & ~empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign push    = rx_push & (~full | pop);
   assign ovr_set = rx_push & full & ~pop;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= rx_byte;
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovr    <= 1'b0;
         ferr   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         ovr  <= (ovr  & ~clr_flags) | ovr_set;
         ferr <= (ferr & ~clr_flags) | ferr_set;
      end
   end

   always_comb begin
      rdata_c = '0;
      if (hit) begin
         if (bus.address[0])
            rdata_c = {11'b0, ferr, ovr, full, (tx_state != TX_IDLE), ~empty};
         else if (!empty)
            rdata_c = {8'h00, mem[rd_ptr]};
      end
   end

   assign bus.rdata = rdata_c;
endmodule
